// File: rtl/param_menu_ctrl.sv
// -----------------------------------------------------------------------------
// param_menu_ctrl
// Front-end controller for a bank of signed parameter cells:
//   * debounces the next / prev / restore menu keys (active-low, raw)
//   * keeps a one-hot cell selection that wraps at both ends
//   * turns a long restore-key hold into a single restore strobe
//   * streams a preset image into the cells, one cell per clock
// Optional build macro: PARAM_MENU_RESTORE_ALL_EN
//   defined   -> during the restore strobe every cell is selected
//   undefined -> restore only reaches the currently selected cell
// Reset is synchronous and active-low (resetn). All outputs are registered.
// -----------------------------------------------------------------------------
module param_menu_ctrl #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int NUM_PARAMS      = 8,
  parameter int PARAM_WIDTH     = 8,
  parameter int DEBOUNCE_MS     = 20,
  parameter int RESTORE_HOLD_MS = 1000
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              clk_ms,
  input  logic                              akey_next,
  input  logic                              akey_prev,
  input  logic                              akey_restore,
  input  logic                              preset_req,
  input  logic [NUM_PARAMS*PARAM_WIDTH-1:0] preset_data,
  output logic [NUM_PARAMS-1:0]             selected,
  output logic [$clog2(NUM_PARAMS)-1:0]     sel_index,
  output logic                              restore,
  output logic [NUM_PARAMS-1:0]             load_valid,
  output logic [PARAM_WIDTH-1:0]            load_data,
  output logic                              busy,
  output logic                              load_done
);

  localparam int IW        = $clog2(NUM_PARAMS);
  localparam int DW        = $clog2(DEBOUNCE_MS + 1);
  localparam int HW        = $clog2(RESTORE_HOLD_MS + 1);
  localparam int K_NEXT    = 0;
  localparam int K_PREV    = 1;
  localparam int K_RESTORE = 2;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_PARAMS - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESTORE_HOLD_MS - 1);

  // CLK_FREQ is informational only; all timing is derived from clk_ms.
  if (CLK_FREQ <= 0) begin : g_clk_freq_invalid
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One-hot decode of a cell index.
  function automatic logic [NUM_PARAMS-1:0] onehot(input logic [IW-1:0] idx);
    return {{(NUM_PARAMS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Synchronizers and debounce state ([0]=next, [1]=prev, [2]=restore).
  logic [2:0]          ms_sync_q;   // [0] first FF, [1] second FF, [2] previous sample
  logic                tick_s;
  logic [2:0]          key_meta_q;
  logic [2:0]          key_sync_q;
  logic [2:0]          key_acc_q, key_acc_d;
  logic [2:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]          key_press_s;

  // Restore hold tracking.
  logic [HW-1:0]       hold_q, hold_d;
  logic                fired_q, fired_d;
  logic                fire_s;

  // Selection and load sequencer.
  logic [IW-1:0]                     sel_q, sel_d;
  state_e                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic [NUM_PARAMS*PARAM_WIDTH-1:0] shadow_q, shadow_d;
  logic                              busy_q, busy_d;
  logic [NUM_PARAMS-1:0]             lv_q, lv_d;
  logic [PARAM_WIDTH-1:0]            ld_q, ld_d;
  logic                              done_q, done_d;
  logic                              restore_q, restore_d;
  logic [NUM_PARAMS-1:0]             selected_q, selected_d;

  // Rising edge of the synchronized ms square wave.
  assign tick_s = ms_sync_q[1] & ~ms_sync_q[2];

  // Per-key debounce: count ticks of disagreement, accept after DEBOUNCE_MS.
  always_comb begin
    key_acc_d   = key_acc_q;
    db_cnt_d    = db_cnt_q;
    key_press_s = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (key_sync_q[k] == key_acc_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (tick_s) begin
        if (db_cnt_q[k] == DB_LAST) begin
          key_acc_d[k]   = key_sync_q[k];
          db_cnt_d[k]    = '0;
          key_press_s[k] = ~key_sync_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DW'(1);
        end
      end else begin
        db_cnt_d[k] = db_cnt_q[k];
      end
    end
  end

  // Restore hold timer: fires once per press, re-armed by the next press.
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    fire_s  = 1'b0;
    if (key_acc_q[K_RESTORE]) begin
      hold_d = '0;
      if (key_press_s[K_RESTORE]) begin
        fired_d = 1'b0;
      end else begin
        fired_d = fired_q;
      end
    end else if (tick_s && !fired_q) begin
      if (hold_q == HOLD_LAST) begin
        fire_s  = 1'b1;
        fired_d = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end else begin
      hold_d = hold_q;
    end
  end

  // Selection index: wrap by explicit compare; ignore keys while loading.
  always_comb begin
    sel_d = sel_q;
    case ({busy_q, key_press_s[K_NEXT], key_press_s[K_PREV]})
      3'b010:  sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + IW'(1);
      3'b001:  sel_d = (sel_q == '0) ? LAST_IDX : sel_q - IW'(1);
      default: sel_d = sel_q;
    endcase
  end

  // Preset load sequencer: next-state and load outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    busy_d   = busy_q;
    lv_d     = '0;
    ld_d     = ld_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (preset_req) begin
          shadow_d = preset_data;
          busy_d   = 1'b1;
          idx_d    = '0;
          state_d  = S_LOAD;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_LOAD: begin
        lv_d = onehot(idx_q);
        ld_d = shadow_q[int'(idx_q)*PARAM_WIDTH +: PARAM_WIDTH];
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Restore strobe and cell select vector (blanked while loading).
  always_comb begin
    restore_d = fire_s & ~busy_q;
    if (busy_d) begin
      selected_d = '0;
    end else begin
`ifdef PARAM_MENU_RESTORE_ALL_EN
      if (restore_d) begin
        selected_d = '1;
      end else begin
        selected_d = onehot(sel_d);
      end
`else
      selected_d = onehot(sel_d);
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_sync_q  <= 3'b000;
      key_meta_q <= 3'b111;
      key_sync_q <= 3'b111;
      key_acc_q  <= 3'b111;
      db_cnt_q   <= '0;
      hold_q     <= '0;
      fired_q    <= 1'b0;
      sel_q      <= '0;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      busy_q     <= 1'b0;
      lv_q       <= '0;
      ld_q       <= '0;
      done_q     <= 1'b0;
      restore_q  <= 1'b0;
      selected_q <= {{(NUM_PARAMS-1){1'b0}}, 1'b1};
    end else begin
      ms_sync_q  <= {ms_sync_q[1], ms_sync_q[0], clk_ms};
      key_meta_q <= {akey_restore, akey_prev, akey_next};
      key_sync_q <= key_meta_q;
      key_acc_q  <= key_acc_d;
      db_cnt_q   <= db_cnt_d;
      hold_q     <= hold_d;
      fired_q    <= fired_d;
      sel_q      <= sel_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
      lv_q       <= lv_d;
      ld_q       <= ld_d;
      done_q     <= done_d;
      restore_q  <= restore_d;
      selected_q <= selected_d;
    end
  end

  assign selected   = selected_q;
  assign sel_index  = sel_q;
  assign restore    = restore_q;
  assign load_valid = lv_q;
  assign load_data  = ld_q;
  assign busy       = busy_q;
  assign load_done  = done_q;

endmodule

// File: doc/param_menu_ctrl.md
Name: param_menu_ctrl

Overview:
Control stage directly upstream of a bank of signed parameter cells. Debounces three raw menu keys (next, prev, restore) and drives a one-hot `selected` vector. Turns a long press of the restore key into a one-cycle `restore` pulse. Sequences a preset image into the cells one cell per clock over a shared `load_data` bus with per-cell `load_valid` strobes.

Parameters:
CLK_FREQ, 50_000000, system clock frequency in Hz (documentation only; all timing uses clk_ms)
NUM_PARAMS, 8, number of downstream parameter cells, 2..32
PARAM_WIDTH, 8, width of one parameter value
DEBOUNCE_MS, 20, number of consecutive ms ticks a key level must be stable before it is accepted
RESTORE_HOLD_MS, 1000, hold time of the restore key before restore fires

Ports:
clk  in  1  system clock
resetn  in  1  reset (see Behaviour)
clk_ms  in  1  asynchronous 1 kHz square wave
akey_next  in  1  raw key, active-low (released = 1)
akey_prev  in  1  raw key, active-low
akey_restore  in  1  raw key, active-low
preset_req  in  1  single-cycle request to load a preset
preset_data  in  NUM_PARAMS*PARAM_WIDTH  preset image; cell i occupies bits [i*PARAM_WIDTH +: PARAM_WIDTH]
selected  out  NUM_PARAMS  one-hot select to the cells
sel_index  out  $clog2(NUM_PARAMS)  current selection index
restore  out  1  one-cycle restore strobe
load_valid  out  NUM_PARAMS  per-cell load strobe; at most one bit high
load_data  out  PARAM_WIDTH  shared load value
busy  out  1  preset load in progress
load_done  out  1  one-cycle pulse when the load completes

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. Reset values:
  - sel_index=0, selected=1 (bit 0 set)
  - restore=0, load_valid=0, load_data=0, busy=0, load_done=0
  - FSM in IDLE, all debounced key states = released, all counters cleared
- Reset asserted mid-load aborts the load. No further load_valid is issued.
- All outputs are registered.
- ms tick:
  - clk_ms passes through a 2-FF synchronizer.
  - Its rising edge produces a one-clk `tick`.
- Debounce, per key:
  - Raw key passes through a 2-FF synchronizer.
  - A counter is cleared whenever the synced level equals the accepted state.
  - Otherwise the counter increments on each tick.
  - When the count reaches DEBOUNCE_MS, the accepted state takes the synced level and the counter clears.
  - An accepted 1→0 transition produces a one-cycle `press` event.
- Selection:
  - press_next: sel_index+1; wraps from NUM_PARAMS-1 to 0.
  - press_prev: sel_index-1; wraps from 0 to NUM_PARAMS-1.
  - Both events in the same cycle: no change.
  - selected = 1<<sel_index, updated in the same cycle as sel_index.
- Restore:
  - A hold counter runs on tick while accepted restore = pressed.
  - It clears on release.
  - When the count reaches RESTORE_HOLD_MS, restore=1 for exactly one clk.
  - No repeat until the key is released and pressed again.
  - A release before RESTORE_HOLD_MS produces nothing.
- Load FSM, states IDLE → LOAD → DONE → IDLE:
  - IDLE: preset_req=1 at edge t latches preset_data into a shadow register, sets busy=1, clears idx, and enters LOAD.
  - LOAD: after edge t+1+i, load_valid = 1<<i and load_data = shadow slice i, for i = 0..NUM_PARAMS-1.
  - After the last cell, enter DONE.
  - DONE: load_valid=0, load_done=1 for one cycle, busy=0, return to IDLE.
  - preset_req while busy is ignored.
- While busy:
  - selected=0, so the cells ignore keys.
  - press events and restore firing are discarded; the hold counter keeps running.
  - sel_index is preserved, and selected is restored on the cycle busy falls.
- Width: the index counter is $clog2(NUM_PARAMS) bits; wrap is an explicit compare, not power-of-two overflow.

Optional Feature:
Macro: PARAM_MENU_RESTORE_ALL_EN.
- Defined: in the cycle restore=1, selected is all ones, so every cell returns to its default. The next cycle selected returns to 1<<sel_index.
- Undefined: selected stays one-hot, so only the current cell restores.

Test Plan:
Use NUM_PARAMS=4, PARAM_WIDTH=8, DEBOUNCE_MS=2, RESTORE_HOLD_MS=5 unless noted.
1. Reset, then press next 5 times, each held 4 ms → sel_index 1,2,3,0,1; final selected=4'b0010; a 1 ms glitch produces no change.
2. From sel_index=0, press prev once → sel_index=3, selected=4'b1000. Next and prev pressed simultaneously → sel_index unchanged.
3. Hold restore 10 ms → exactly one restore pulse, about 7 ms after key-down (2 ms debounce + 5 ms hold). Hold 3 ms → none. With RESTORE_ALL_EN defined, the pulse cycle shows selected=4'b1111.
4. preset_data=32'h80_7F_02_FE with one-cycle preset_req →
   - load_valid 0001/0010/0100/1000 on four consecutive cycles, starting two edges after the request
   - load_data FE,02,7F,80
   - then load_done=1; busy high throughout; selected=0 during the load
5. Second preset_req during the load → ignored, still exactly 4 strobes. Next pressed during the load → sel_index unchanged afterwards.
6. resetn low on the 2nd load strobe → next cycle all outputs at reset values, no further strobes; a new preset_req works normally.
